// File: rtl/sram_bus_arb_pkg.sv
// rtl/sram_bus_arb_pkg.sv - shared state, port-id and access-size constants for the SRAM bus arbiter
package sram_bus_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_e;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Contention goes to whichever port did not win last time.
  function automatic logic pick_winner(input logic i_req, input logic d_req,
                                       input logic last_grant);
    if (i_req && d_req) return ~last_grant;
    return d_req ? PORT_D : PORT_I;
  endfunction

endpackage

// File: rtl/sram_bus_arb_if.sv
// rtl/sram_bus_arb_if.sv - one SRAM-like request/response port (address phase + data phase)
interface sram_bus_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [DATA_W/8-1:0] wstrb;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );

endinterface

// File: rtl/sram_req_mux.sv
// rtl/sram_req_mux.sv - steers the owner's request onto the bus and fans handshakes back by owner
module sram_req_mux #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                owner_i,
  input  logic                addr_phase_i,
  input  logic                data_phase_i,
  input  logic                i_wr_i,
  input  logic [1:0]          i_size_i,
  input  logic [DATA_W/8-1:0] i_wstrb_i,
  input  logic [ADDR_W-1:0]   i_addr_i,
  input  logic [DATA_W-1:0]   i_wdata_i,
  input  logic                d_wr_i,
  input  logic [1:0]          d_size_i,
  input  logic [DATA_W/8-1:0] d_wstrb_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  input  logic                bus_addr_ok_i,
  input  logic                bus_data_ok_i,
  input  logic [DATA_W-1:0]   bus_rdata_i,
  output logic                bus_req_o,
  output logic                bus_wr_o,
  output logic [1:0]          bus_size_o,
  output logic [DATA_W/8-1:0] bus_wstrb_o,
  output logic [ADDR_W-1:0]   bus_addr_o,
  output logic [DATA_W-1:0]   bus_wdata_o,
  output logic                i_addr_ok_o,
  output logic                d_addr_ok_o,
  output logic                i_data_ok_o,
  output logic                d_data_ok_o,
  output logic [DATA_W-1:0]   rdata_o
);
  import sram_bus_arb_pkg::*;

  logic own_d;
  logic resp;

  assign own_d = (owner_i == PORT_D);
  assign resp  = data_phase_i && bus_data_ok_i;

  // Request fields are only driven while the address phase is open; zero otherwise.
  always_comb begin
    bus_req_o   = addr_phase_i;
    bus_wr_o    = 1'b0;
    bus_size_o  = 2'd0;
    bus_wstrb_o = '0;
    bus_addr_o  = '0;
    bus_wdata_o = '0;
    if (addr_phase_i) begin
      if (own_d) begin
        bus_wr_o    = d_wr_i;
        bus_size_o  = d_size_i;
        bus_wstrb_o = d_wstrb_i;
        bus_addr_o  = d_addr_i;
        bus_wdata_o = d_wdata_i;
      end else begin
        bus_wr_o    = i_wr_i;
        bus_size_o  = i_size_i;
        bus_wstrb_o = i_wstrb_i;
        bus_addr_o  = i_addr_i;
        bus_wdata_o = i_wdata_i;
      end
    end
  end

  assign i_addr_ok_o = addr_phase_i && !own_d && bus_addr_ok_i;
  assign d_addr_ok_o = addr_phase_i &&  own_d && bus_addr_ok_i;
  assign i_data_ok_o = resp && !own_d;
  assign d_data_ok_o = resp &&  own_d;
  assign rdata_o     = resp ? bus_rdata_i : '0;

endmodule

// File: rtl/sram_bus_arb.sv
// rtl/sram_bus_arb.sv - arbitrates fetch (I) and load/store (D) ports onto one SRAM-like bus
module sram_bus_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  sram_bus_arb_if.slave   i_port,
  sram_bus_arb_if.slave   d_port,
  sram_bus_arb_if.master  bus
);
  import sram_bus_arb_pkg::*;

  arb_state_e state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_grant_q, last_grant_d;
  logic       winner;
  logic [DATA_W-1:0] rdata_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      owner_q      <= PORT_I;
      last_grant_q <= PORT_I;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Stray addr_ok/data_ok outside their own phase are simply not looked at.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    winner       = pick_winner(i_port.req, d_port.req, last_grant_q);
    case (state_q)
      ARB_IDLE: begin
        if (i_port.req || d_port.req) begin
          owner_d      = winner;
          last_grant_d = winner;
          state_d      = ARB_ADDR;
        end
      end
      ARB_ADDR: if (bus.addr_ok) state_d = ARB_DATA;
      ARB_DATA: if (bus.data_ok) state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  sram_req_mux #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_req_mux (
    .owner_i      (owner_q),
    .addr_phase_i (state_q == ARB_ADDR),
    .data_phase_i (state_q == ARB_DATA),
    .i_wr_i       (i_port.wr),
    .i_size_i     (i_port.size),
    .i_wstrb_i    (i_port.wstrb),
    .i_addr_i     (i_port.addr),
    .i_wdata_i    (i_port.wdata),
    .d_wr_i       (d_port.wr),
    .d_size_i     (d_port.size),
    .d_wstrb_i    (d_port.wstrb),
    .d_addr_i     (d_port.addr),
    .d_wdata_i    (d_port.wdata),
    .bus_addr_ok_i(bus.addr_ok),
    .bus_data_ok_i(bus.data_ok),
    .bus_rdata_i  (bus.rdata),
    .bus_req_o    (bus.req),
    .bus_wr_o     (bus.wr),
    .bus_size_o   (bus.size),
    .bus_wstrb_o  (bus.wstrb),
    .bus_addr_o   (bus.addr),
    .bus_wdata_o  (bus.wdata),
    .i_addr_ok_o  (i_port.addr_ok),
    .d_addr_ok_o  (d_port.addr_ok),
    .i_data_ok_o  (i_port.data_ok),
    .d_data_ok_o  (d_port.data_ok),
    .rdata_o      (rdata_w)
  );

  // Both ports see the same response bus; data_ok tells them whose it is.
  assign i_port.rdata = rdata_w;
  assign d_port.rdata = rdata_w;

endmodule

// File: tb/tb_sram_bus_arb.sv
// tb/tb_sram_bus_arb.sv - directed bench with a transaction-level reference for sram_bus_arb
module tb_sram_bus_arb;
  import sram_bus_arb_pkg::*;

  logic clk;
  logic rst;

  sram_bus_arb_if #(.ADDR_W(32), .DATA_W(32)) ifi ();
  sram_bus_arb_if #(.ADDR_W(32), .DATA_W(32)) ifd ();
  sram_bus_arb_if #(.ADDR_W(32), .DATA_W(32)) ifb ();

  sram_bus_arb #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .i_port (ifi),
    .d_port (ifd),
    .bus    (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: one transaction record (who owns it, whether its address was taken).
  bit m_busy, m_accepted, m_port, m_last;

  always @(posedge clk) begin
    if (!rst && m_busy && !m_accepted && ifb.addr_ok)
      check("slave_addr_and_data_same_cycle", ifb.data_ok, 1'b0);
    if (rst) begin
      m_busy = 0; m_accepted = 0; m_port = 0; m_last = 0;
    end else if (!m_busy) begin
      if (ifi.req || ifd.req) begin
        if (ifi.req && ifd.req) m_port = !m_last;
        else                    m_port = ifd.req;
        m_last = m_port; m_busy = 1; m_accepted = 0;
      end
    end else if (!m_accepted) begin
      if (ifb.addr_ok) m_accepted = 1;
    end else if (ifb.data_ok) begin
      m_busy = 0;
    end
  end

  logic        e_req, e_wr, e_iaok, e_daok, e_idok, e_ddok;
  logic [1:0]  e_size;
  logic [3:0]  e_wstrb;
  logic [31:0] e_addr, e_wdata, e_rdata;
  logic [71:0] prev_iv, prev_dv, cur_iv, cur_dv;
  bit          prev_i_hold = 0, prev_d_hold = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      e_req   = m_busy && !m_accepted;
      e_wr    = e_req ? (m_port ? ifd.wr    : ifi.wr)    : 1'b0;
      e_size  = e_req ? (m_port ? ifd.size  : ifi.size)  : 2'd0;
      e_wstrb = e_req ? (m_port ? ifd.wstrb : ifi.wstrb) : 4'd0;
      e_addr  = e_req ? (m_port ? ifd.addr  : ifi.addr)  : 32'd0;
      e_wdata = e_req ? (m_port ? ifd.wdata : ifi.wdata) : 32'd0;
      e_iaok  = e_req && !m_port && ifb.addr_ok;
      e_daok  = e_req &&  m_port && ifb.addr_ok;
      e_idok  = m_busy && m_accepted && !m_port && ifb.data_ok;
      e_ddok  = m_busy && m_accepted &&  m_port && ifb.data_ok;
      e_rdata = (e_idok || e_ddok) ? ifb.rdata : 32'd0;
      check("bus_req", ifb.req, e_req);
      if (!(m_busy && m_accepted)) begin
        check("bus_wr", ifb.wr, e_wr);
        check("bus_size", ifb.size, e_size);
        check("bus_wstrb", ifb.wstrb, e_wstrb);
        check("bus_addr", ifb.addr, e_addr);
        check("bus_wdata", ifb.wdata, e_wdata);
      end
      check("i_addr_ok", ifi.addr_ok, e_iaok);
      check("d_addr_ok", ifd.addr_ok, e_daok);
      check("i_data_ok", ifi.data_ok, e_idok);
      check("d_data_ok", ifd.data_ok, e_ddok);
      check("i_rdata", ifi.rdata, e_rdata);
      check("d_rdata", ifd.rdata, e_rdata);
      // Requesters must not move their request until it has been accepted.
      cur_iv = {ifi.req, ifi.wr, ifi.size, ifi.wstrb, ifi.addr, ifi.wdata};
      cur_dv = {ifd.req, ifd.wr, ifd.size, ifd.wstrb, ifd.addr, ifd.wdata};
      if (prev_i_hold) check("i_request_held", cur_iv, prev_iv);
      if (prev_d_hold) check("d_request_held", cur_dv, prev_dv);
      prev_iv = cur_iv;
      prev_dv = cur_dv;
      prev_i_hold = ifi.req && !e_iaok && !rst;
      prev_d_hold = ifd.req && !e_daok && !rst;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  bit          acc_port[$];
  logic [31:0] acc_addr[$];

  // Both ports issue back-to-back word reads; zero-wait-ish slave (addr_ok on the
  // second address cycle, data_ok on the first data cycle).
  task automatic run_contention(input int n_i, input int n_d,
                                input logic [31:0] ia0, input logic [31:0] da0);
    int rem_i, rem_d, guard;
    logic [31:0] ia, da;
    bit in_data, s_req, s_iok, s_dok, s_aok, s_dat;
    rem_i = n_i; rem_d = n_d; ia = ia0; da = da0; in_data = 0; guard = 0;
    acc_port.delete(); acc_addr.delete();
    ifi.wr = 0; ifi.size = SZ_WORD; ifi.wstrb = 4'hF; ifi.wdata = 0; ifi.addr = ia;
    ifd.wr = 0; ifd.size = SZ_WORD; ifd.wstrb = 4'hF; ifd.wdata = 0; ifd.addr = da;
    ifi.req = (rem_i > 0);
    ifd.req = (rem_d > 0);
    while ((rem_i > 0 || rem_d > 0 || in_data) && guard < 100) begin
      sample();
      s_req = ifb.req; s_iok = ifi.addr_ok; s_dok = ifd.addr_ok;
      s_aok = ifb.addr_ok; s_dat = ifb.data_ok;
      if (s_iok) begin acc_port.push_back(1'b0); acc_addr.push_back(ifb.addr); end
      if (s_dok) begin acc_port.push_back(1'b1); acc_addr.push_back(ifb.addr); end
      cyc();
      if (s_iok) begin rem_i--; ia = ia + 32'd4; ifi.addr = ia; end
      if (s_dok) begin rem_d--; da = da + 32'd4; ifd.addr = da; end
      ifi.req = (rem_i > 0);
      ifd.req = (rem_d > 0);
      in_data = s_aok || (in_data && !s_dat);
      ifb.addr_ok = s_req && !s_aok;
      ifb.data_ok = in_data;
      ifb.rdata   = in_data ? (32'hC0DE0000 + guard) : 32'd0;
      guard++;
    end
    check("contention_completed_in_budget", guard < 100, 1'b1);
  endtask

  bit exp6[6];
  int pulses;

  initial begin
    exp6 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    rst = 1;
    ifi.req = 0; ifi.wr = 0; ifi.size = 0; ifi.wstrb = 0; ifi.addr = 0; ifi.wdata = 0;
    ifd.req = 0; ifd.wr = 0; ifd.size = 0; ifd.wstrb = 0; ifd.addr = 0; ifd.wdata = 0;
    ifb.addr_ok = 0; ifb.data_ok = 0; ifb.rdata = 0;
    cyc();
    chk_en = 1;
    sample();
    check("lit_reset_bus_req", ifb.req, 1'b0);
    check("lit_reset_i_addr_ok", ifi.addr_ok, 1'b0);
    check("lit_reset_d_data_ok", ifd.data_ok, 1'b0);
    check("lit_reset_rdata", ifi.rdata, 32'd0);
    cyc();
    rst = 0;

    // Single fetch: cycles 0..5
    ifi.req = 1; ifi.addr = 32'h1C000000; ifi.size = SZ_WORD; ifi.wstrb = 4'hF;
    sample(); check("lit_fetch_c0_bus_req", ifb.req, 1'b0);
    cyc(); sample();
    check("lit_fetch_c1_bus_req", ifb.req, 1'b1);
    check("lit_fetch_c1_bus_addr", ifb.addr, 32'h1C000000);
    cyc(); ifb.addr_ok = 1; sample();
    check("lit_fetch_c2_i_addr_ok", ifi.addr_ok, 1'b1);
    check("lit_fetch_c2_bus_req", ifb.req, 1'b1);
    cyc(); ifb.addr_ok = 0; ifi.req = 0; ifi.addr = 0; sample();
    check("lit_fetch_c3_bus_req", ifb.req, 1'b0);
    cyc(); ifb.data_ok = 1; ifb.rdata = 32'h02800000; sample();
    check("lit_fetch_c4_i_data_ok", ifi.data_ok, 1'b1);
    check("lit_fetch_c4_rdata", ifi.rdata, 32'h02800000);
    check("lit_fetch_c4_d_data_ok", ifd.data_ok, 1'b0);
    cyc(); ifb.data_ok = 0; ifb.rdata = 0; sample();
    check("lit_fetch_c5_i_data_ok", ifi.data_ok, 1'b0);

    // Simultaneous requests: D goes first since last_grant is I after reset
    run_contention(1, 1, 32'h1C000000, 32'h1C008000);
    check("lit_simul_count", acc_port.size(), 2);
    if (acc_port.size() >= 2) begin
      check("lit_simul_first_port", acc_port[0], 1'b1);
      check("lit_simul_first_addr", acc_addr[0], 32'h1C008000);
      check("lit_simul_second_port", acc_port[1], 1'b0);
      check("lit_simul_second_addr", acc_addr[1], 32'h1C000000);
    end

    // Back-to-back contention: D, I, D, I, D, I
    run_contention(3, 3, 32'h1C000100, 32'h1C008100);
    check("lit_b2b_count", acc_port.size(), 6);
    for (int k = 0; k < 6; k++)
      if (k < acc_port.size()) check($sformatf("lit_b2b_grant%0d", k), acc_port[k], exp6[k]);

    // Byte store from D; bus data_ok held one extra cycle into IDLE must not re-pulse
    cyc();
    ifd.req = 1; ifd.wr = 1; ifd.size = SZ_BYTE; ifd.wstrb = 4'b0100;
    ifd.addr = 32'h1C000102; ifd.wdata = 32'h00AB0000;
    sample();
    cyc(); ifb.addr_ok = 1; sample();
    check("lit_store_bus_wr", ifb.wr, 1'b1);
    check("lit_store_bus_size", ifb.size, SZ_BYTE);
    check("lit_store_bus_wstrb", ifb.wstrb, 4'b0100);
    check("lit_store_bus_addr", ifb.addr, 32'h1C000102);
    check("lit_store_bus_wdata", ifb.wdata, 32'h00AB0000);
    check("lit_store_d_addr_ok", ifd.addr_ok, 1'b1);
    cyc(); ifb.addr_ok = 0; ifd.req = 0; ifd.wr = 0; ifd.wstrb = 0; ifd.addr = 0; ifd.wdata = 0;
    ifb.data_ok = 1; sample();
    pulses = int'(ifd.data_ok);
    cyc(); sample();
    pulses += int'(ifd.data_ok);
    check("lit_store_data_ok_pulses", pulses, 1);
    cyc(); ifb.data_ok = 0;

    // Spurious data_ok in IDLE, then a 5-cycle address stall with a stray data_ok
    ifb.data_ok = 1; ifb.rdata = 32'h55555555; sample();
    check("lit_spur_idle_i_data_ok", ifi.data_ok, 1'b0);
    check("lit_spur_idle_d_data_ok", ifd.data_ok, 1'b0);
    check("lit_spur_idle_rdata", ifd.rdata, 32'd0);
    cyc(); ifb.data_ok = 0; ifb.rdata = 0;
    ifi.req = 1; ifi.wr = 0; ifi.size = SZ_HALF; ifi.wstrb = 4'b0011; ifi.addr = 32'h1C000040;
    sample();
    for (int k = 0; k < 5; k++) begin
      cyc();
      ifb.data_ok = (k == 2);
      sample();
      check($sformatf("lit_stall%0d_bus_req", k), ifb.req, 1'b1);
      check($sformatf("lit_stall%0d_bus_addr", k), ifb.addr, 32'h1C000040);
      check($sformatf("lit_stall%0d_i_data_ok", k), ifi.data_ok, 1'b0);
    end
    cyc(); ifb.data_ok = 0; ifb.addr_ok = 1; sample();
    check("lit_stall_i_addr_ok", ifi.addr_ok, 1'b1);
    cyc(); ifb.addr_ok = 0; ifi.req = 0; ifi.addr = 0; ifi.size = 0; ifi.wstrb = 0;
    ifb.data_ok = 1; ifb.rdata = 32'h00001234; sample();
    check("lit_stall_i_data_ok", ifi.data_ok, 1'b1);
    check("lit_stall_rdata", ifi.rdata, 32'h00001234);
    cyc(); ifb.data_ok = 0; ifb.rdata = 0;

    // Reset while in DATA; the late response must be dropped
    ifd.req = 1; ifd.size = SZ_WORD; ifd.wstrb = 4'hF; ifd.addr = 32'h1C000200;
    sample();
    cyc(); ifb.addr_ok = 1; sample();
    cyc(); ifb.addr_ok = 0; ifd.req = 0; ifd.addr = 0; sample();
    check("lit_rstdata_bus_req", ifb.req, 1'b0);
    cyc(); rst = 1; sample();
    cyc(); rst = 0; sample();
    check("lit_after_rst_bus_req", ifb.req, 1'b0);
    check("lit_after_rst_bus_addr", ifb.addr, 32'd0);
    check("lit_after_rst_d_data_ok", ifd.data_ok, 1'b0);
    check("lit_after_rst_rdata", ifd.rdata, 32'd0);
    cyc(); sample();
    cyc(); ifb.data_ok = 1; ifb.rdata = 32'hDEADBEEF; sample();
    check("lit_late_d_data_ok", ifd.data_ok, 1'b0);
    check("lit_late_rdata", ifd.rdata, 32'd0);
    cyc(); ifb.data_ok = 0; ifb.rdata = 0;
    run_contention(0, 1, 32'h1C000300, 32'h1C000400);
    check("lit_post_rst_count", acc_port.size(), 1);
    if (acc_port.size() >= 1) check("lit_post_rst_port", acc_port[0], 1'b1);

    cyc(); cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/sram_bus_arb.md
Name: sram_bus_arb

Overview:
- Arbitrates the shared SRAM-like memory bus between the IF-stage fetch port (port I) and the MEM-stage load/store port (port D).
- Sequences each transaction through an address phase (req/addr_ok) and a data phase (data_ok), one outstanding transaction at a time.
- Routes the response back to the owning port. The MEM-stage ready_go and the IF-stage ready_go are derived from this block's data_ok outputs.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; wstrb width is DATA_W/8

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
i_req  in  1  fetch request
i_wr  in  1  fetch write flag (normally 0)
i_size  in  2  access size: 0=byte, 1=half, 2=word
i_wstrb  in  DATA_W/8  fetch byte strobes
i_addr  in  ADDR_W  fetch address
i_wdata  in  DATA_W  fetch write data
i_addr_ok  out  1  fetch address accepted
i_data_ok  out  1  fetch response valid
d_req, d_wr, d_size, d_wstrb, d_addr, d_wdata  in  (same widths as I)  load/store request fields
d_addr_ok  out  1  load/store address accepted
d_data_ok  out  1  load/store response valid
rdata  out  DATA_W  response data, shared by both ports
bus_req  out  1  bus request
bus_wr  out  1  bus write flag
bus_size  out  2  bus access size
bus_wstrb  out  DATA_W/8  bus byte strobes
bus_addr  out  ADDR_W  bus address
bus_wdata  out  DATA_W  bus write data
bus_addr_ok  in  1  bus address accepted
bus_data_ok  in  1  bus response valid
bus_rdata  in  DATA_W  bus response data

Behaviour:
- State machine: IDLE, ADDR, DATA. Registers: state, owner (0=I, 1=D), last_grant (0=I, 1=D).
- Reset: state=IDLE, owner=0, last_grant=0. All outputs are 0 in IDLE, including bus_req and every addr_ok/data_ok.
- IDLE arbitration:
  - Only d_req asserted → grant D.
  - Only i_req asserted → grant I.
  - Both asserted → grant the port not equal to last_grant. After reset, last_grant=0, so D wins the first contention.
  - On a grant: owner<=winner, last_grant<=winner, state<=ADDR.
  - No request → stay in IDLE.
  - Grant takes 1 cycle: a req seen in cycle N produces bus_req=1 in cycle N+1.
- ADDR:
  - bus_req=1. bus_wr, bus_size, bus_wstrb, bus_addr and bus_wdata are combinationally muxed from the owner's inputs.
  - Owner's addr_ok = bus_addr_ok. The non-owner's addr_ok = 0.
  - On bus_addr_ok: state<=DATA.
  - Requesters must hold req and all request fields stable until they see addr_ok. The bench asserts this.
- DATA:
  - bus_req=0.
  - Owner's data_ok = bus_data_ok. rdata = bus_rdata, combinationally.
  - On bus_data_ok: state<=IDLE. The next grant is therefore earliest in the cycle after data_ok.
  - Responses for writes are also signalled by data_ok. rdata is don't-care for writes.
- rdata: valid only while some data_ok is 1. In all other cycles rdata=0.
- Ignored inputs:
  - bus_data_ok in IDLE or ADDR is spurious and is ignored; it produces no data_ok.
  - bus_addr_ok outside ADDR is ignored.
- Same-cycle bus_addr_ok and bus_data_ok while in ADDR: accept only the address. The data_ok is lost. The slave must not do this, and the bench asserts it.
- Non-owner request during ADDR/DATA: held pending, no addr_ok. It is arbitrated at the next IDLE.
- Reset mid-transaction: state returns to IDLE and outputs drop in the next cycle. A bus response still in flight is dropped. Flushing the slave is the system's responsibility.
- Throughput: at most one transaction per 3 cycles (IDLE → ADDR → DATA) when the slave has zero wait states.

Decomposition:
- Shared package holds:
  - state encoding constants ARB_IDLE=2'd0, ARB_ADDR=2'd1, ARB_DATA=2'd2;
  - port IDs PORT_I=1'b0, PORT_D=1'b1;
  - size constants SZ_BYTE/SZ_HALF/SZ_WORD.
- One natural sub-module: sram_req_mux. It is purely combinational: it selects the owner's request fields onto the bus and fans out addr_ok/data_ok by owner. The FSM and arbitration stay in the top module.

Test Plan:
- Single fetch:
  - Stimulus: i_req=1, i_addr=0x1C000000; slave gives addr_ok at cycle 2 and data_ok at cycle 4 with rdata=0x02800000.
  - Required: bus_req=1 in cycles 1–2; i_addr_ok=1 at cycle 2; i_data_ok=1 and rdata=0x02800000 at cycle 4; d_* outputs stay 0 throughout.
- Simultaneous requests after reset:
  - Stimulus: i_req and d_req both asserted, d_addr=0x1C008000.
  - Required: D is served first. After D's data_ok, I is granted; bus_addr=I's address 1 cycle after state returns to IDLE.
- Back-to-back contention:
  - Stimulus: both ports request continuously for 6 transactions.
  - Required: grant sequence D, I, D, I, D, I.
- Store:
  - Stimulus: d_wr=1, d_size=0, d_wstrb=4'b0100, d_addr=0x1C000102, d_wdata=0x00AB0000.
  - Required: the bus carries identical values while in ADDR; d_data_ok is pulsed once.
- Spurious and ignored responses:
  - Stimulus: bus_data_ok=1 pulsed while in IDLE; a stall of 5 wait cycles with no addr_ok.
  - Required: no data_ok outputs during the spurious pulse; bus_req and the request fields stay stable throughout the wait.
- Reset mid-DATA:
  - Stimulus: rst asserted in DATA, with the late data_ok arriving 2 cycles after reset deasserts.
  - Required: all outputs 0 the cycle after rst; the late data_ok is ignored; a new d_req is served normally.
